// File: rtl/xif_mem_responder.sv
// xif_mem_responder
//   Core-side responder for the CORE-V-XIF memory interface of rvfpm.
//   Takes FLW/FSW requests from the coprocessor and forwards them in order
//   onto an OBI-style data bus (req/gnt address phase, then in-order rvalid).
//   Each accepted request gets exactly one result, tagged with its id.
//   Misaligned or unsupported-size requests are answered locally with err=1
//   and never reach the bus.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   mem_valid/ready     request handshake, mem_req = x_mem_req_t (82 bits)
//   mem_result_valid    one-cycle pulse qualifying mem_result = x_mem_result_t (38 bits)
//   bus_req/gnt         bus address phase; bus_we/addr/be/wdata held until gnt
//   bus_rvalid          in-order response, one per grant, with bus_rdata/bus_err
//   proto_err           sticky: bus_rvalid seen with nothing outstanding
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the initiator keeps its payload stable while valid && !ready.
// bus_req behaves as valid (held until bus_gnt); bus_rvalid and
// mem_result_valid are single-cycle pulses with no backpressure.
module xif_mem_responder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [81:0] mem_req,
  output logic        mem_result_valid,
  output logic [37:0] mem_result,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        proto_err
);

  localparam int ID_W  = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [1:0]      mode;
    logic            we;
    logic [2:0]      size;
    logic [3:0]      be;
    logic [1:0]      attr;
    logic [31:0]     wdata;
    logic            last;
    logic            spec;
  } mem_req_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     rdata;
    logic            err;
    logic            dbg;
  } mem_result_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  mem_req_t        req;
  mem_result_t     result_q;
  logic [1:0]      size_mask;
  logic            bad;
  logic            accept;
  logic            push;
  logic            pop;
  logic [ID_W-1:0] req_id_q;
  logic [ID_W-1:0] fifo_id [DEPTH];
  logic            fifo_we [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic            unused_req_fields;

  assign req        = mem_req;
  assign mem_result = result_q;

  // mode/attr/last/spec carry no meaning for this responder.
  assign unused_req_fields = ^{req.mode, req.attr, req.last, req.spec};

  // Low address bits that must be zero for the access size.
  always_comb begin
    case (req.size)
      3'd0:    size_mask = 2'b00;
      3'd1:    size_mask = 2'b01;
      default: size_mask = 2'b11;
    endcase
  end

  assign bad    = (req.size > 3'd2) || ((req.addr[1:0] & size_mask) != 2'b00);
  assign accept = mem_valid && mem_ready;
  assign push   = (state == REQ) && bus_gnt;
  // An rvalid with nothing outstanding is a bus protocol error, not a pop.
  assign pop    = bus_rvalid && (count != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bad ? ERR : REQ;
      REQ:     if (bus_gnt) state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. A bad request is only taken with an empty FIFO so that its
  // error result can never land in the same cycle as a bus response result.
  always_comb begin
    bus_req   = (state == REQ);
    mem_ready = (state == IDLE) && (count < CNT_W'(DEPTH)) && !(bad && (count != '0));
  end

  // Bus address stage: loaded on a good accept, held through REQ until grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_id_q  <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else if (accept) begin
      req_id_q <= req.id;
      if (!bad) begin
        bus_we    <= req.we;
        bus_addr  <= req.addr;
        bus_be    <= req.be;
        bus_wdata <= req.wdata;
      end
    end
  end

  // Outstanding-transaction FIFO of {id, we}, pushed on grant, popped on rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_id[i] <= '0;
        fifo_we[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_id[wr_ptr] <= req_id_q;
        fifo_we[wr_ptr] <= bus_we;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Result register. The error result is registered at accept time so it is
  // presented during the single ERR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_result_valid <= 1'b0;
      result_q         <= '0;
      proto_err        <= 1'b0;
    end else begin
      mem_result_valid <= 1'b0;
      if (accept && bad) begin
        mem_result_valid <= 1'b1;
        result_q         <= {req.id, 32'd0, 1'b1, 1'b0};
      end else if (pop) begin
        mem_result_valid <= 1'b1;
        result_q         <= {fifo_id[rd_ptr], (fifo_we[rd_ptr] ? 32'd0 : bus_rdata), bus_err, 1'b0};
      end
      if (bus_rvalid && (count == '0)) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xif_mem_responder.sv
// Testbench for xif_mem_responder: directed scenarios plus a randomized run
// checked against a transaction-level model (queues of outstanding requests
// and expected results).
module tb_xif_mem_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [81:0] mem_req;
  logic        mem_result_valid;
  logic [37:0] mem_result;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, wanted test completion");
    $fatal(1, "watchdog expired");
  end

  xif_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_req          (mem_req),
    .mem_result_valid (mem_result_valid),
    .mem_result       (mem_result),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_be           (bus_be),
    .bus_wdata        (bus_wdata),
    .bus_gnt          (bus_gnt),
    .bus_rvalid       (bus_rvalid),
    .bus_rdata        (bus_rdata),
    .bus_err          (bus_err),
    .proto_err        (proto_err)
  );

  // ---------------- helpers ----------------
  function automatic logic [81:0] mk_req(input logic [3:0] id, input logic [31:0] addr,
                                         input logic we, input logic [2:0] size,
                                         input logic [3:0] be, input logic [31:0] wdata);
    return {id, addr, 2'b00, we, size, be, 2'b00, wdata, 1'b0, 1'b0};
  endfunction

  // Legal: size 0/1/2 with the address naturally aligned to 1<<size bytes.
  function automatic bit is_bad(input logic [31:0] addr, input logic [2:0] size);
    int sz;
    sz = int'(size);
    if (sz > 2) return 1'b1;
    return (addr % (32'd1 << sz)) != 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_valid  = 1'b0;
    mem_req    = '0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    bus_err    = 1'b0;
  endtask

  // Present a request and hold it until the handshake edge (bounded wait).
  task automatic issue(input logic [81:0] r, input string name);
    int n;
    n = 0;
    mem_valid = 1'b1;
    mem_req   = r;
    #1;
    while (mem_ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL %s_accept_timeout: mem_ready=%b after %0d cycles, wanted 1", name, mem_ready, n);
    end
    cyc();
    mem_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if ({mem_ready, mem_result_valid, bus_req, proto_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: ready/rv/req/perr=%b wanted 1000", {mem_ready, mem_result_valid, bus_req, proto_err});
    end
    n_checks++;
    if (mem_result !== 38'd0) begin
      n_fail++; $display("FAIL reset_result: got %h wanted 0", mem_result);
    end
    n_checks++;
    if ({bus_we, bus_addr, bus_be, bus_wdata} !== 69'd0) begin
      n_fail++; $display("FAIL reset_bus_fields: got %h wanted 0", {bus_we, bus_addr, bus_be, bus_wdata});
    end
  endtask

  task automatic test_load();
    issue(mk_req(4'd3, 32'h100, 1'b0, 3'd2, 4'hF, 32'h0), "load");
    n_checks++;
    if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      n_fail++; $display("FAIL load_bus: req/we/addr/be=%h wanted %h", {bus_req, bus_we, bus_addr, bus_be}, {1'b1, 1'b0, 32'h100, 4'hF});
    end
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    n_checks++;
    if ({bus_req, mem_result_valid} !== 2'b00) begin
      n_fail++; $display("FAIL load_after_gnt: req/rv=%b wanted 00", {bus_req, mem_result_valid});
    end
    cyc();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEADBEEF;
    cyc();
    bus_rvalid = 1'b0;
    n_checks++;
    if (mem_result_valid !== 1'b1 || mem_result !== {4'd3, 32'hDEADBEEF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL load_result: valid=%b result=%h wanted 1 %h", mem_result_valid, mem_result, {4'd3, 32'hDEADBEEF, 1'b0, 1'b0});
    end
    cyc();
    n_checks++;
    if (mem_result_valid !== 1'b0) begin
      n_fail++; $display("FAIL load_pulse_width: valid=%b wanted 0", mem_result_valid);
    end
  endtask

  task automatic test_fill();
    logic [31:0] data [4];
    for (int i = 1; i <= 4; i++) begin
      issue(mk_req(4'(i), 32'h40 * i, 1'b0, 3'd2, 4'hF, 32'h0), "fill");
      bus_gnt = 1'b1;
      cyc();
      bus_gnt = 1'b0;
    end
    mem_req = mk_req(4'd9, 32'h500, 1'b0, 3'd2, 4'hF, 32'h0);
    #1;
    n_checks++;
    if (mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full_ready: mem_ready=%b wanted 0", mem_ready);
    end
    cyc();
    n_checks++;
    if ({mem_ready, mem_result_valid, bus_req} !== 3'b000) begin
      n_fail++; $display("FAIL fill_full_hold: ready/rv/req=%b wanted 000", {mem_ready, mem_result_valid, bus_req});
    end
    for (int i = 0; i < 4; i++) begin
      data[i]    = $urandom;
      bus_rvalid = 1'b1;
      bus_rdata  = data[i];
      cyc();
      n_checks++;
      if (mem_result_valid !== 1'b1 || mem_result !== {4'(i + 1), data[i], 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL fill_result_%0d: valid=%b result=%h wanted 1 %h", i, mem_result_valid, mem_result, {4'(i + 1), data[i], 1'b0, 1'b0});
      end
    end
    bus_rvalid = 1'b0;
    n_checks++;
    if (mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_drained_ready: mem_ready=%b wanted 1", mem_ready);
    end
    cyc();
  endtask

  task automatic test_misaligned();
    logic [81:0] bad_req;
    bad_req   = mk_req(4'd5, 32'h102, 1'b0, 3'd2, 4'hF, 32'h0);
    mem_valid = 1'b1;
    mem_req   = bad_req;
    #1;
    n_checks++;
    if (mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL misaligned_empty_ready: mem_ready=%b wanted 1", mem_ready);
    end
    cyc();
    mem_valid = 1'b0;
    n_checks++;
    if (bus_req !== 1'b0 || mem_result_valid !== 1'b1 || mem_result !== {4'd5, 32'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL misaligned_result: req=%b valid=%b result=%h wanted 0 1 %h", bus_req, mem_result_valid, mem_result, {4'd5, 32'd0, 1'b1, 1'b0});
    end
    cyc();
    n_checks++;
    if ({bus_req, mem_result_valid} !== 2'b00) begin
      n_fail++; $display("FAIL misaligned_after: req/rv=%b wanted 00", {bus_req, mem_result_valid});
    end
    // Same bad request while one load is outstanding.
    issue(mk_req(4'd6, 32'h300, 1'b0, 3'd2, 4'hF, 32'h0), "misaligned_load");
    bus_gnt = 1'b1;
    cyc();
    bus_gnt   = 1'b0;
    mem_valid = 1'b1;
    mem_req   = bad_req;
    #1;
    n_checks++;
    if (mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_busy_ready: mem_ready=%b wanted 0", mem_ready);
    end
    cyc();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFEF00D;
    #1;
    n_checks++;
    if (mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_rvalid_ready: mem_ready=%b wanted 0", mem_ready);
    end
    cyc();
    bus_rvalid = 1'b0;
    n_checks++;
    if (mem_result_valid !== 1'b1 || mem_result !== {4'd6, 32'hCAFEF00D, 1'b0, 1'b0} || mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL misaligned_load_result: valid=%b result=%h ready=%b wanted 1 %h 1", mem_result_valid, mem_result, mem_ready, {4'd6, 32'hCAFEF00D, 1'b0, 1'b0});
    end
    cyc();
    mem_valid = 1'b0;
    n_checks++;
    if (mem_result_valid !== 1'b1 || mem_result !== {4'd5, 32'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL misaligned_late_result: valid=%b result=%h wanted 1 %h", mem_result_valid, mem_result, {4'd5, 32'd0, 1'b1, 1'b0});
    end
    cyc();
  endtask

  task automatic test_store_err();
    issue(mk_req(4'd7, 32'h200, 1'b1, 3'd2, 4'hF, 32'h12345678), "store");
    mem_req = mk_req(4'd1, 32'hFFFF_FFFC, 1'b0, 3'd2, 4'h3, 32'hAAAA5555);
    repeat (2) cyc();
    n_checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, 32'h200, 4'hF, 32'h12345678}) begin
      n_fail++; $display("FAIL store_bus_hold: got %h wanted %h", {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, {1'b1, 1'b1, 32'h200, 4'hF, 32'h12345678});
    end
    bus_gnt = 1'b1;
    cyc();
    bus_gnt = 1'b0;
    cyc();
    bus_rvalid = 1'b1;
    bus_err    = 1'b1;
    bus_rdata  = 32'hFFFFFFFF;
    cyc();
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
    n_checks++;
    if (mem_result_valid !== 1'b1 || mem_result !== {4'd7, 32'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL store_err_result: valid=%b result=%h wanted 1 %h", mem_result_valid, mem_result, {4'd7, 32'd0, 1'b1, 1'b0});
    end
    cyc();
  endtask

  task automatic test_random();
    logic [4:0]  outst_q [$];   // {id, we} granted and awaiting rvalid
    logic [37:0] exp_q [$];     // results due on the next cycle
    int          busy;          // 0 free, 1 bus request pending, 2 error result pending
    logic [3:0]  p_id, id;
    logic        p_we, we;
    logic [31:0] p_addr, p_wdata, addr, wdata;
    logic [3:0]  p_be, be;
    logic [2:0]  size;
    logic [81:0] r;
    logic [4:0]  e;
    logic [37:0] exp_r;
    bit          exp_v, bad, exp_ready;
    busy = 0;
    p_id = '0; p_we = 1'b0; p_addr = '0; p_wdata = '0; p_be = '0;
    drive_idle();
    for (int t = 0; t < 600; t++) begin
      exp_v = (exp_q.size() != 0);
      exp_r = exp_v ? exp_q.pop_front() : 38'd0;
      n_checks++;
      if (mem_result_valid !== exp_v) begin
        n_fail++; $display("FAIL rand_result_valid t=%0d: got %b wanted %b", t, mem_result_valid, exp_v);
      end else if (exp_v) begin
        n_checks++;
        if (mem_result !== exp_r) begin
          n_fail++; $display("FAIL rand_result t=%0d: got %h wanted %h", t, mem_result, exp_r);
        end
      end
      n_checks++;
      if (bus_req !== (busy == 1)) begin
        n_fail++; $display("FAIL rand_bus_req t=%0d: got %b wanted %b", t, bus_req, busy == 1);
      end
      if (busy == 1) begin
        n_checks++;
        if ({bus_we, bus_addr, bus_be, bus_wdata} !== {p_we, p_addr, p_be, p_wdata}) begin
          n_fail++; $display("FAIL rand_bus_fields t=%0d: got %h wanted %h", t, {bus_we, bus_addr, bus_be, bus_wdata}, {p_we, p_addr, p_be, p_wdata});
        end
      end
      id    = 4'($urandom);
      addr  = $urandom;
      we    = 1'($urandom);
      be    = 4'($urandom);
      wdata = $urandom;
      size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r     = mk_req(id, addr, we, size, be, wdata);
      r[45:44] = 2'($urandom);
      r[35:34] = 2'($urandom);
      r[1:0]   = 2'($urandom);
      mem_req   = r;
      bus_rdata = $urandom;
      bus_err   = ($urandom_range(0, 3) == 0);
      if (t < 550) begin
        mem_valid  = 1'($urandom_range(0, 1));
        bus_gnt    = (busy == 1) && ($urandom_range(0, 2) == 0);
        bus_rvalid = (outst_q.size() != 0) && ($urandom_range(0, 2) == 0);
      end else begin
        mem_valid  = 1'b0;
        bus_gnt    = (t < 590) && (busy == 1);
        bus_rvalid = (t < 590) && (outst_q.size() != 0);
      end
      #1;
      bad       = is_bad(addr, size);
      exp_ready = (busy == 0) && (outst_q.size() < DEPTH) && !(bad && outst_q.size() != 0);
      n_checks++;
      if (mem_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_mem_ready t=%0d: got %b wanted %b", t, mem_ready, exp_ready);
      end
      if (bus_rvalid) begin
        e = outst_q.pop_front();
        exp_q.push_back({e[4:1], (e[0] ? 32'd0 : bus_rdata), bus_err, 1'b0});
      end
      if (busy == 1 && bus_gnt) begin
        outst_q.push_back({p_id, p_we});
        busy = 0;
      end else if (busy == 2) begin
        busy = 0;
      end
      if (mem_valid && exp_ready) begin
        if (bad) begin
          exp_q.push_back({id, 32'd0, 1'b1, 1'b0});
          busy = 2;
        end else begin
          busy = 1;
          p_id = id; p_we = we; p_addr = addr; p_be = be; p_wdata = wdata;
        end
      end
      cyc();
    end
    drive_idle();
    mem_req = mk_req(4'd0, 32'h0, 1'b0, 3'd2, 4'hF, 32'h0);
    #1;
    n_checks++;
    if ({mem_ready, bus_req, proto_err} !== 3'b100) begin
      n_fail++; $display("FAIL rand_drained: ready/req/perr=%b wanted 100", {mem_ready, bus_req, proto_err});
    end
    cyc();
  endtask

  task automatic test_proto();
    drive_idle();
    bus_rvalid = 1'b1;
    bus_rdata  = $urandom;
    cyc();
    bus_rvalid = 1'b0;
    n_checks++;
    if ({mem_result_valid, proto_err} !== 2'b01) begin
      n_fail++; $display("FAIL proto_set: rv/perr=%b wanted 01", {mem_result_valid, proto_err});
    end
    repeat (3) cyc();
    n_checks++;
    if ({mem_result_valid, proto_err} !== 2'b01) begin
      n_fail++; $display("FAIL proto_sticky: rv/perr=%b wanted 01", {mem_result_valid, proto_err});
    end
  endtask

  task automatic test_reset_mid_req();
    issue(mk_req(4'd9, 32'h80, 1'b0, 3'd2, 4'hF, 32'h0), "reset_mid");
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_req_pre: bus_req=%b wanted 1", bus_req);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_async: bus_req=%b wanted 0", bus_req);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    n_checks++;
    if ({mem_ready, mem_result_valid, proto_err, bus_req} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_mid_after: ready/rv/perr/req=%b wanted 1000", {mem_ready, mem_result_valid, proto_err, bus_req});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    cyc();
    test_load();
    test_fill();
    test_misaligned();
    test_store_err();
    test_random();
    test_proto();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
